// File: rtl/crc_frame_builder.sv
// Collects NIBBLES 4-bit beats into one message, presents it with valid/ready,
// and discards streams that gap mid-frame or overrun a held frame.
module crc_frame_builder #(
   parameter int NIBBLES = 15,
   parameter int CNT_W   = 8
) (
   input  logic                 clk_1,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [3:0]           in_nibble,
   input  logic                 in_mode,
   input  logic                 in_crc,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [4*NIBBLES-1:0] out_message,
   output logic                 out_mode,
   output logic                 out_crc,
   output logic                 out_fire,
   output logic                 frame_err,
   output logic                 busy,
   output logic [CNT_W-1:0]     frame_cnt
);
   localparam int         MSG_W    = 4 * NIBBLES;
   localparam int         POS_W    = $clog2(MSG_W);
   localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

   state_t           r_state;
   logic [3:0]       r_beat_idx;
   logic [MSG_W-1:0] r_message;
   logic             r_mode;
   logic             r_crc;
   logic             r_valid;
   logic             r_err;
   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;

   logic [POS_W-1:0] w_msb;
   logic [MSG_W-1:0] w_first;

   // Top bit of the nibble slot addressed by the current beat index.
   assign w_msb   = POS_W'(MSG_W - 1) - POS_W'({r_beat_idx, 2'b00});
   assign w_first = {in_nibble, {(MSG_W-4){1'b0}}};

   always_ff @(posedge clk_1 or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_beat_idx <= 4'd0;
         r_message  <= '0;
         r_mode     <= 1'b0;
         r_crc      <= 1'b0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_message  <= w_first;
                  r_mode     <= in_mode;
                  r_crc      <= in_crc;
                  r_beat_idx <= 4'd1;
                  r_busy     <= 1'b1;
                  r_state    <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (in_valid) begin
                  r_message[w_msb -: 4] <= in_nibble;
                  if (r_beat_idx == LAST_IDX) begin
                     r_beat_idx <= 4'd0;
                     r_valid    <= 1'b1;
                     r_state    <= S_HOLD;
                  end else begin
                     r_beat_idx <= r_beat_idx + 4'd1;
                  end
               end else begin
                  // A gap breaks the frame: drop what was gathered so far.
                  r_err      <= 1'b1;
                  r_message  <= '0;
                  r_beat_idx <= 4'd0;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_valid <= 1'b0;
                  // A beat arriving with the transfer opens the next frame.
                  if (in_valid) begin
                     r_message  <= w_first;
                     r_mode     <= in_mode;
                     r_crc      <= in_crc;
                     r_beat_idx <= 4'd1;
                     r_state    <= S_COLLECT;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else if (in_valid) begin
                  r_err <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign out_valid   = r_valid;
   assign out_message = r_message;
   assign out_mode    = r_mode;
   assign out_crc     = r_crc;
   assign out_fire    = r_valid & out_ready;
   assign frame_err   = r_err;
   assign busy        = r_busy;
   assign frame_cnt   = r_cnt;
endmodule

// File: tb/tb_crc_frame_builder.sv
// Randomized bench for crc_frame_builder: frames are built from nibble lists and
// the expected message, timing, error pulses and frame count come from frame rules.
module tb_crc_frame_builder;
   logic        clk_1 = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_nibble;
   logic        in_mode;
   logic        in_crc;
   logic        out_ready;
   logic        out_valid;
   logic [59:0] out_message;
   logic        out_mode;
   logic        out_crc;
   logic        out_fire;
   logic        frame_err;
   logic        busy;
   logic [7:0]  frame_cnt;

   always #5 clk_1 = ~clk_1;

   crc_frame_builder #(.NIBBLES(15), .CNT_W(8)) dut (
      .clk_1      (clk_1),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_nibble  (in_nibble),
      .in_mode    (in_mode),
      .in_crc     (in_crc),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_message(out_message),
      .out_mode   (out_mode),
      .out_crc    (out_crc),
      .out_fire   (out_fire),
      .frame_err  (frame_err),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   int         total = 0;
   int         bad   = 0;
   bit         err_pend = 1'b0;   // an offending input occurred in the previous cycle
   int         exp_cnt  = 0;
   logic [3:0] cur_nibs [15];
   logic       cur_m;
   logic       cur_c;
   bit         cur_started = 1'b0; // first beat already sent in a transfer cycle

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [3:0] rn();
      return 4'($urandom_range(0, 15));
   endfunction

   // Message value of the current frame: first beat is the most significant nibble.
   function automatic logic [59:0] expected_msg();
      logic [59:0] m = '0;
      for (int i = 0; i < 15; i++) m = (m << 4) | 60'(cur_nibs[i]);
      return m;
   endfunction

   task automatic tick();
      @(posedge clk_1);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] n, input logic m, input logic c,
                        input logic r, input bit offense);
      in_valid  = v;
      in_nibble = n;
      in_mode   = m;
      in_crc    = c;
      out_ready = r;
      #1;
      check("frame_err", frame_err, err_pend);
      err_pend = offense;
   endtask

   task automatic gen_frame(input bit fixed, input logic [3:0] val);
      for (int i = 0; i < 15; i++) cur_nibs[i] = fixed ? val : rn();
      cur_m = rb();
      cur_c = rb();
   endtask

   task automatic collect(input int upto);
      for (int i = (cur_started ? 1 : 0); i < upto; i++) begin
         if (i == 0) begin
            drive(1'b1, cur_nibs[0], cur_m, cur_c, rb(), 1'b0);
            check("busy_idle", busy, 1'b0);
         end else begin
            drive(1'b1, cur_nibs[i], rb(), rb(), rb(), 1'b0);
            check("busy_collect", busy, 1'b1);
            check("valid_collect", out_valid, 1'b0);
         end
         tick();
      end
      cur_started = 1'b0;
   endtask

   task automatic hold(input int wait_cyc, input int ov_mode, input bit b2b);
      logic [59:0] m  = expected_msg();
      logic        em = cur_m;
      logic        ec = cur_c;
      for (int w = 0; w < wait_cyc; w++) begin
         bit ov = (ov_mode == 2) || (ov_mode == 1 && $urandom_range(0, 1) == 1);
         drive(ov, rn(), rb(), rb(), 1'b0, ov);
         check("hold_valid", out_valid, 1'b1);
         check("hold_fire", out_fire, 1'b0);
         check("hold_msg", out_message, m);
         check("hold_busy", busy, 1'b1);
         tick();
      end
      if (b2b) begin
         gen_frame(1'b0, 4'h0);
         cur_started = 1'b1;
         drive(1'b1, cur_nibs[0], cur_m, cur_c, 1'b1, 1'b0);
      end else begin
         drive(1'b0, rn(), rb(), rb(), 1'b1, 1'b0);
      end
      check("fire", out_fire, 1'b1);
      check("fire_valid", out_valid, 1'b1);
      check("fire_msg", out_message, m);
      check("fire_mode", out_mode, em);
      check("fire_crc", out_crc, ec);
      tick();
      exp_cnt = (exp_cnt + 1) % 256;
      check("frame_cnt", frame_cnt, exp_cnt);
      check("post_valid", out_valid, 1'b0);
      check("post_fire", out_fire, 1'b0);
      if (b2b) begin
         check("b2b_busy", busy, 1'b1);
         check("b2b_first", out_message[59:56], cur_nibs[0]);
      end else begin
         check("idle_busy", busy, 1'b0);
         check("msg_kept", out_message, m);
      end
   endtask

   task automatic abort(input int k);
      gen_frame(1'b0, 4'h0);
      collect(k);
      drive(1'b0, rn(), rb(), rb(), rb(), 1'b1);
      check("gap_busy", busy, 1'b1);
      tick();
      check("abort_busy", busy, 1'b0);
      check("abort_valid", out_valid, 1'b0);
      check("abort_msg", out_message, 60'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, rn(), rb(), rb(), rb(), 1'b0);
         check("idle_valid", out_valid, 1'b0);
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_nibble = 4'h0; in_mode = 1'b0; in_crc = 1'b0; out_ready = 1'b0;
      #3;
      check("rst_msg", out_message, 60'h0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_cnt", frame_cnt, 8'h0);
      check("rst_err", frame_err, 1'b0);
      @(posedge clk_1);
      #1;
      rst = 1'b0;

      // basic frame 1..F
      for (int i = 0; i < 15; i++) cur_nibs[i] = 4'(i + 1);
      cur_m = 1'b0;
      cur_c = 1'b1;
      collect(15);
      check("basic_msg", out_message, 60'h123456789ABCDEF);
      check("basic_crc", out_crc, 1'b1);
      hold(0, 0, 1'b0);

      // back-pressure: 10 stalled cycles then transfer
      gen_frame(1'b1, 4'hA);
      collect(15);
      check("bp_msg", out_message, 60'hAAAAAAAAAAAAAAA);
      hold(10, 0, 1'b0);

      // gap abort after 7 beats, then a full frame of 5s
      abort(7);
      gen_frame(1'b1, 4'h5);
      collect(15);
      check("gap_next_msg", out_message, 60'h555555555555555);
      hold(0, 0, 1'b0);

      // overrun beat while held, then a frame started in the transfer cycle
      gen_frame(1'b0, 4'h0);
      collect(15);
      hold(1, 2, 1'b1);
      collect(15);
      check("b2b_valid", out_valid, 1'b1);
      hold(0, 0, 1'b0);

      // asynchronous reset in the middle of beat 9
      gen_frame(1'b1, 4'h3);
      cur_m = 1'b1;
      cur_c = 1'b1;
      collect(9);
      drive(1'b1, cur_nibs[9], rb(), rb(), 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check("arst_msg", out_message, 60'h0);
      check("arst_mode", out_mode, 1'b0);
      check("arst_crc", out_crc, 1'b0);
      check("arst_cnt", frame_cnt, 8'h0);
      check("arst_valid", out_valid, 1'b0);
      check("arst_fire", out_fire, 1'b0);
      check("arst_err", frame_err, 1'b0);
      check("arst_busy", busy, 1'b0);
      in_valid = 1'b0;
      #1;
      rst = 1'b0;
      err_pend = 1'b0;
      exp_cnt  = 0;
      tick();
      gen_frame(1'b1, 4'hF);
      collect(15);
      check("ones_msg", out_message, 60'hFFFFFFFFFFFFFFF);
      hold(0, 0, 1'b0);

      // randomized frames: aborts, stalls, overruns and back-to-back starts
      for (int f = 0; f < 40; f++) begin
         if (!cur_started && $urandom_range(0, 4) == 0) begin
            abort(int'($urandom_range(1, 14)));
            idle(int'($urandom_range(0, 2)));
         end else begin
            if (!cur_started) gen_frame(1'b0, 4'h0);
            collect(15);
            hold(int'($urandom_range(0, 4)), 1, 1'($urandom_range(0, 1)));
            if (!cur_started) idle(int'($urandom_range(0, 2)));
         end
      end
      if (cur_started) begin
         collect(15);
         hold(0, 0, 1'b0);
      end
      idle(2);

      // counter wrap over 256 transfers
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      err_pend = 1'b0;
      exp_cnt  = 0;
      for (int f = 0; f < 256; f++) begin
         if (!cur_started) gen_frame(1'b0, 4'h0);
         collect(15);
         hold(0, 0, f != 255);
      end
      check("wrap_cnt", frame_cnt, 8'h0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
